conv_window_feeder: RTL and testbench
=====================================

CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 8, pixels per image row (2..65535).
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 8, rows per frame (2..65535).
REQ-003 The block SHALL have parameter WIN_SIZE, default 3, window edge in pixels; it equals the downstream window's P_SR_DEPTH and NUM_SR_ROWS (1..min(IMG_WIDTH,IMG_HEIGHT)).
REQ-004 The block SHALL have ports: clock  in  1  sole clock; reset  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports: start  in  1  frame start request; busy  out  1  frame in progress.
REQ-006 The block SHALL have ports: in_pixel  in  8  raster-order pixel; in_valid  in  1  pixel offered; in_ready  out  1  pixel accepted when in_valid && in_ready.
REQ-007 The block SHALL have ports: sr_enable  out  1  shift strobe to the window shift register; sr_pixel  out  8  column shift-in data.
REQ-008 The block SHALL have ports: win_valid  out  1  window complete; win_ready  in  1  window consumed when win_valid && win_ready; win_row, win_col  out  16 each  window top-left coordinate; frame_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-009 The FSM SHALL have states IDLE, STREAM, DRAIN and DONE.
REQ-010 IDLE SHALL go to STREAM when start=1, clearing the row and column counters; busy SHALL be 1 in every state except IDLE.
REQ-011 start SHALL be ignored in every state except IDLE.
REQ-012 in_ready SHALL be 1 only in STREAM and only when !(win_valid && !win_ready); in_ready depends combinationally on win_ready.
REQ-013 sr_enable SHALL equal in_valid && in_ready, and sr_pixel SHALL equal in_pixel, both combinationally, so the shift register shifts on the same edge that accepts the pixel.
REQ-014 Each accepted pixel SHALL advance the column counter; at IMG_WIDTH-1 the column counter wraps to 0 and the row counter increments.
REQ-015 When the accepted pixel has row >= WIN_SIZE-1 and col >= WIN_SIZE-1, win_valid SHALL be 1 in the next cycle, with win_row = row-(WIN_SIZE-1) and win_col = col-(WIN_SIZE-1), giving stride 1 and one cycle of latency.
REQ-016 win_valid, win_row and win_col SHALL hold stable until the handshake; win_valid SHALL clear on the handshake unless a new window is produced on the same edge.
REQ-017 A handshake and a new pixel acceptance on the same edge SHALL be legal; the new window SHALL replace the consumed one with no gap.
REQ-018 Accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1) SHALL move the FSM to DRAIN, with in_ready=0 thereafter.
REQ-019 DRAIN SHALL go to DONE when win_valid is 0 or its handshake occurs.
REQ-020 DONE SHALL assert frame_done for exactly one cycle and then return to IDLE.
REQ-021 Cycles with in_valid=0 SHALL leave all counters and outputs unchanged.
REQ-022 The downstream window RAM shift depth SHALL be IMG_WIDTH-WIN_SIZE, which is a system-integration constraint; this block does not check it.

Reset
REQ-023 Reset SHALL force: state IDLE; counters 0; busy=0, win_valid=0, win_row=0, win_col=0, frame_done=0, in_ready=0, sr_enable=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame immediately; no frame_done pulse follows.

Structure
REQ-025 The FSM state enum and COORD_W=16 SHALL reside in the shared package conv_sr_pkg.
REQ-026 The row/column counter pair SHALL be a sub-module named raster_counter, with ports for increment, clear, wrap flag and last-pixel flag.

Verification
REQ-027 With IMG 4x4, WIN_SIZE 3, win_ready=1 and continuous pixels, the bench SHALL see exactly 4 windows at (0,0),(0,1),(1,0),(1,1); the first win_valid appears one cycle after the 11th accepted pixel; frame_done pulses once.
REQ-028 Same setup with win_ready held 0 for 5 cycles at the first window: in_ready=0 and sr_enable=0 throughout, and win_row/win_col stay (0,0).
REQ-029 With WIN_SIZE=1 and IMG 2x2, the bench SHALL see 4 windows at (0,0),(0,1),(1,0),(1,1), each one cycle after its pixel.
REQ-030 Pulsing start=1 in STREAM and DRAIN SHALL cause no counter change and no extra frame.
REQ-031 Reset asserted after 6 pixels SHALL return all outputs to reset values the same cycle; a following start SHALL begin again at (0,0).
REQ-032 Random in_valid gaps on IMG 5x4, WIN_SIZE 3 SHALL produce the same window sequence as gap-free input: 6 windows, raster order.

Source files
------------

// File: rtl/conv_sr_pkg.sv
// conv_sr_pkg -- shared definitions for the convolution window feeder.
//   COORD_W        : width of row/column coordinates
//   feeder_state_t : frame sequencing states of conv_window_feeder
package conv_sr_pkg;

    localparam int unsigned COORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/raster_counter.sv
// raster_counter -- raster-order row/column position counter.
//   clock, reset : clock, asynchronous active-high reset
//   clear        : synchronous return to (0,0)
//   incr         : advance one pixel in raster order
//   row, col     : current position
//   col_wrap     : col is the last column of the row
//   last_pixel   : position is the last pixel of the frame
module raster_counter
    import conv_sr_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned IMG_HEIGHT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               incr,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               col_wrap,
    output logic               last_pixel
);

    assign col_wrap   = (col == COORD_W'(IMG_WIDTH - 1));
    assign last_pixel = col_wrap && (row == COORD_W'(IMG_HEIGHT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (incr) begin
            if (col_wrap) begin
                col <= '0;
                row <= last_pixel ? '0 : row + COORD_W'(1);
            end else begin
                col <= col + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder -- streams a raster-order frame into a window shift
// register and announces each complete WIN_SIZE x WIN_SIZE window (stride 1).
//   clock, reset          : clock, asynchronous active-high reset
//   start, busy           : frame start request, frame in progress
//   in_pixel/valid/ready  : pixel input handshake
//   sr_enable, sr_pixel   : shift strobe and column data for the shift register
//   win_valid/ready       : window handshake; win_row/win_col = top-left corner
//   frame_done            : one-cycle end-of-frame pulse
module conv_window_feeder
    import conv_sr_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned IMG_HEIGHT = 8,
    parameter int unsigned WIN_SIZE   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    input  logic [7:0]         in_pixel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               sr_enable,
    output logic [7:0]         sr_pixel,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               frame_done
);

    feeder_state_t      state, state_next;
    logic               cnt_clear;
    logic               accept;
    logic               win_hit;
    logic [COORD_W-1:0] row, col;
    logic               col_wrap, last_pixel;
    logic [COORD_W:0]   row_p1, col_p1;

    raster_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_raster (
        .clock     (clock),
        .reset     (reset),
        .clear     (cnt_clear),
        .incr      (accept),
        .row       (row),
        .col       (col),
        .col_wrap  (col_wrap),
        .last_pixel(last_pixel)
    );

    // A pending, unconsumed window blocks new pixels so it cannot be overwritten.
    assign in_ready  = (state == STREAM) && !(win_valid && !win_ready);
    assign accept    = in_valid && in_ready;
    assign sr_enable = accept;
    assign sr_pixel  = in_pixel;

    // Compare position+1 against WIN_SIZE so WIN_SIZE=1 needs no special case.
    assign row_p1  = {1'b0, row} + (COORD_W + 1)'(1);
    assign col_p1  = {1'b0, col} + (COORD_W + 1)'(1);
    assign win_hit = accept && (row_p1 >= (COORD_W + 1)'(WIN_SIZE))
                            && (col_p1 >= (COORD_W + 1)'(WIN_SIZE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        cnt_clear  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = STREAM;
                    cnt_clear  = 1'b1;
                end
            end
            STREAM: begin
                if (accept && last_pixel) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!win_valid || win_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A new window on the handshake edge replaces the consumed one seamlessly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (win_hit) begin
            win_valid <= 1'b1;
            win_row   <= row - COORD_W'(WIN_SIZE - 1);
            win_col   <= col - COORD_W'(WIN_SIZE - 1);
        end else if (win_valid && win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder -- randomized self-checking bench for conv_window_feeder.
// Three instances: 4x4/WIN 3, 2x2/WIN 1, 5x4/WIN 3, sharing clock and reset.
module tb_conv_window_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start = '0, in_valid = '0, win_ready = '0;
    logic [7:0]  in_pixel [3];
    logic [2:0]  busy, in_ready, sr_enable, win_valid, frame_done;
    logic [7:0]  sr_pixel [3];
    logic [15:0] win_row [3];
    logic [15:0] win_col [3];

    int W [3] = '{4, 2, 5};
    int H [3] = '{4, 2, 4};
    int K [3] = '{3, 1, 3};

    // reference model: phase 0 idle, 1 streaming, 2 draining, 3 done
    int ph [3] = '{0, 0, 0};
    int p  [3] = '{0, 0, 0};
    bit mv [3] = '{0, 0, 0};
    int mr [3] = '{0, 0, 0};
    int mc [3] = '{0, 0, 0};

    // observations of the instance under test
    int cur_g = 0;
    int fd_cnt [3] = '{0, 0, 0};
    int acc_cnt [3] = '{0, 0, 0};
    int first_at [3] = '{-1, -1, -1};
    bit seen [3] = '{0, 0, 0};
    int log_q [$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 3; i++) in_pixel[i] = 8'h00;
    end

    conv_window_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .WIN_SIZE(3)) dut0 (
        .clock(clk), .reset(rst), .start(start[0]), .busy(busy[0]),
        .in_pixel(in_pixel[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .sr_enable(sr_enable[0]), .sr_pixel(sr_pixel[0]),
        .win_valid(win_valid[0]), .win_ready(win_ready[0]),
        .win_row(win_row[0]), .win_col(win_col[0]), .frame_done(frame_done[0]));

    conv_window_feeder #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .WIN_SIZE(1)) dut1 (
        .clock(clk), .reset(rst), .start(start[1]), .busy(busy[1]),
        .in_pixel(in_pixel[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .sr_enable(sr_enable[1]), .sr_pixel(sr_pixel[1]),
        .win_valid(win_valid[1]), .win_ready(win_ready[1]),
        .win_row(win_row[1]), .win_col(win_col[1]), .frame_done(frame_done[1]));

    conv_window_feeder #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .WIN_SIZE(3)) dut2 (
        .clock(clk), .reset(rst), .start(start[2]), .busy(busy[2]),
        .in_pixel(in_pixel[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .sr_enable(sr_enable[2]), .sr_pixel(sr_pixel[2]),
        .win_valid(win_valid[2]), .win_ready(win_ready[2]),
        .win_row(win_row[2]), .win_col(win_col[2]), .frame_done(frame_done[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update: frame progress as pixel index p (row = p / W, col = p % W).
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int g = 0; g < 3; g++) begin
                ph[g] = 0; p[g] = 0; mv[g] = 0; mr[g] = 0; mc[g] = 0;
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                bit rdy, acc, hs, nw;
                int r, c;
                rdy = (ph[g] == 1) && !(mv[g] && !win_ready[g]);
                acc = in_valid[g] && rdy;
                hs  = mv[g] && win_ready[g];
                case (ph[g])
                    0: if (start[g]) begin ph[g] = 1; p[g] = 0; end
                    2: if (!mv[g] || win_ready[g]) ph[g] = 3;
                    3: ph[g] = 0;
                    default: ;
                endcase
                nw = 0;
                if (acc) begin
                    r = p[g] / W[g];
                    c = p[g] % W[g];
                    nw = (r >= K[g] - 1) && (c >= K[g] - 1);
                    if (nw) begin
                        mr[g] = r - (K[g] - 1);
                        mc[g] = c - (K[g] - 1);
                    end
                    p[g]++;
                    if (p[g] == W[g] * H[g]) ph[g] = 2;
                end
                if (nw) mv[g] = 1;
                else if (hs) mv[g] = 0;
            end
        end
    end

    // Compare every instance against the model on every cycle.
    initial forever begin
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            bit ex_rdy, ex_en;
            ex_rdy = (ph[g] == 1) && !(mv[g] && !win_ready[g]);
            ex_en  = in_valid[g] && ex_rdy;
            chk($sformatf("busy%0d", g), 32'(busy[g]), 32'(ph[g] != 0));
            chk($sformatf("in_ready%0d", g), 32'(in_ready[g]), 32'(ex_rdy));
            chk($sformatf("sr_enable%0d", g), 32'(sr_enable[g]), 32'(ex_en));
            if (ex_en) chk($sformatf("sr_pixel%0d", g), 32'(sr_pixel[g]), 32'(in_pixel[g]));
            chk($sformatf("win_valid%0d", g), 32'(win_valid[g]), 32'(mv[g]));
            chk($sformatf("win_row%0d", g), 32'(win_row[g]), 32'(mr[g]));
            chk($sformatf("win_col%0d", g), 32'(win_col[g]), 32'(mc[g]));
            chk($sformatf("frame_done%0d", g), 32'(frame_done[g]), 32'(ph[g] == 3));
            if (g == cur_g) begin
                if (win_valid[g] && !seen[g]) begin
                    seen[g] = 1;
                    first_at[g] = acc_cnt[g];
                end
                if (win_valid[g] && win_ready[g]) begin
                    log_q.push_back(int'(win_row[g]));
                    log_q.push_back(int'(win_col[g]));
                end
                if (frame_done[g]) fd_cnt[g]++;
                if (sr_enable[g]) acc_cnt[g]++;
            end
        end
    end

    task automatic clear_obs(input int g);
        cur_g = g;
        fd_cnt[g] = 0; acc_cnt[g] = 0; first_at[g] = -1; seen[g] = 0;
        log_q.delete();
    endtask

    task automatic check_log(input string nm, input int e [$]);
        chk({nm, "_count"}, 32'(log_q.size() / 2), 32'(e.size() / 2));
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            chk($sformatf("%s_%0d", nm, i), 32'(log_q[i]), 32'(e[i]));
    endtask

    // mode bits: 1 random in_valid gaps, 2 random win_ready, 4 start held high,
    // 8 stall win_ready low for 5 cycles at the first window
    task automatic run_frame(input int g, input int mode, input int budget);
        int n = 0;
        int stall = 0;
        clear_obs(g);
        @(posedge clk); #1;
        start[g] = 1'b1;
        forever begin
            in_pixel[g]  = 8'($urandom);
            in_valid[g]  = (mode & 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mode & 8) win_ready[g] = seen[g] && stall >= 5;
            else if (mode & 2) win_ready[g] = ($urandom_range(0, 3) != 0);
            else win_ready[g] = 1'b1;
            if ((mode & 8) && seen[g] && stall < 5) begin
                @(negedge clk);
                chk("stall_in_ready", 32'(in_ready[g]), 32'd0);
                chk("stall_sr_enable", 32'(sr_enable[g]), 32'd0);
                chk("stall_win_valid", 32'(win_valid[g]), 32'd1);
                chk("stall_win_row", 32'(win_row[g]), 32'd0);
                chk("stall_win_col", 32'(win_col[g]), 32'd0);
                stall++;
            end
            @(posedge clk); #1;
            start[g] = (mode & 4) ? (ph[g] != 3) : 1'b0;
            n++;
            if (fd_cnt[g] != 0 || n >= budget) break;
        end
        start[g] = 1'b0; in_valid[g] = 1'b0; win_ready[g] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("frame_done_once", 32'(fd_cnt[g]), 32'd1);
        chk("idle_after_frame", 32'(busy[g]), 32'd0);
    endtask

    initial begin
        int e4 [$];
        int e6 [$];
        int bud;
        e4 = '{0, 0, 0, 1, 1, 0, 1, 1};
        e6 = '{0, 0, 0, 1, 0, 2, 1, 0, 1, 1, 1, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_win_valid", 32'(win_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 4x4 / WIN 3 gap-free
        run_frame(0, 0, 100);
        check_log("a_win", e4);
        chk("a_first_after", 32'(first_at[0]), 32'd11);

        // first window stalled for 5 cycles
        run_frame(0, 8, 100);
        check_log("b_win", e4);

        // reset after 6 pixels, then a fresh frame
        clear_obs(0);
        @(posedge clk); #1;
        start[0] = 1'b1; in_valid[0] = 1'b1; win_ready[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        bud = 0;
        while (p[0] < 6 && bud < 40) begin
            @(posedge clk); #1;
            bud++;
        end
        chk("e_reached_6", 32'(p[0]), 32'd6);
        rst = 1'b1;
        #1;
        chk("e_busy", 32'(busy[0]), 32'd0);
        chk("e_in_ready", 32'(in_ready[0]), 32'd0);
        chk("e_sr_enable", 32'(sr_enable[0]), 32'd0);
        chk("e_win_valid", 32'(win_valid[0]), 32'd0);
        chk("e_win_row", 32'(win_row[0]), 32'd0);
        chk("e_win_col", 32'(win_col[0]), 32'd0);
        chk("e_frame_done", 32'(frame_done[0]), 32'd0);
        in_valid[0] = 1'b0; win_ready[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("e_no_frame_done", 32'(fd_cnt[0]), 32'd0);
        run_frame(0, 0, 100);
        check_log("e_win", e4);
        chk("e_first_after", 32'(first_at[0]), 32'd11);

        // start held high through STREAM and DRAIN, random win_ready
        run_frame(0, 6, 300);
        check_log("d_win", e4);

        // 2x2 / WIN 1: every pixel is a window
        run_frame(1, 0, 50);
        check_log("c_win", e4);
        chk("c_first_after", 32'(first_at[1]), 32'd1);

        // 5x4 / WIN 3 with random gaps and back-pressure
        for (int rep = 0; rep < 4; rep++) begin
            run_frame(2, 3, 500);
            check_log("f_win", e6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
